rect_fill_engine: RTL



---
 rtl/rect_gpu_pkg.sv | 36 +++
 rtl/rect_clip.sv | 51 +++++
 rtl/rect_fill_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rect_gpu_pkg.sv
// Shared types and mailbox layout for the rectangle fill engine.
// Imported by the engine top and the clip unit.
package rect_gpu_pkg;

  typedef enum logic [3:0] {
    ST_POLL = 4'd0,
    ST_CHK  = 4'd1,
    ST_RD1  = 4'd2,
    ST_CAP1 = 4'd3,
    ST_RD2  = 4'd4,
    ST_CAP2 = 4'd5,
    ST_RD3  = 4'd6,
    ST_CAP3 = 4'd7,
    ST_CLIP = 4'd8,
    ST_DRAW = 4'd9,
    ST_ACK  = 4'd10
  } state_t;

  localparam logic [1:0] MB_CTRL   = 2'd0;
  localparam logic [1:0] MB_P0     = 2'd1;
  localparam logic [1:0] MB_P1     = 2'd2;
  localparam logic [1:0] MB_COLOUR = 2'd3;

  localparam int unsigned BIT_GO      = 0;
  localparam int unsigned BIT_OUTLINE = 1;
  localparam int unsigned BIT_DONE    = 31;

  localparam logic [31:0] DONE_WORD = 32'h8000_0000;

  // Mailbox coordinate word: x in the low half, y in the high half.
  typedef struct packed {
    logic signed [15:0] y;
    logic signed [15:0] x;
  } point_t;

endpackage

// File: rtl/rect_clip.sv
// Orders two signed corners, tests the box against the screen
// and clamps it to the visible area.
module rect_clip
  import rect_gpu_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  point_t      i_p0,
  input  point_t      i_p1,
  output logic        o_empty,
  output logic [15:0] o_xl,
  output logic [15:0] o_xh,
  output logic [15:0] o_yl,
  output logic [15:0] o_yh
);

  localparam logic signed [16:0] XMAX = 17'(H_RES - 1);
  localparam logic signed [16:0] YMAX = 17'(V_RES - 1);
  localparam logic signed [16:0] ZERO = 17'sd0;

  logic signed [16:0] w_x0, w_x1, w_y0, w_y1;
  logic signed [16:0] w_xl, w_xh, w_yl, w_yh;
  logic signed [16:0] w_xlc, w_xhc, w_ylc, w_yhc;

  always_comb begin
    w_x0 = {i_p0.x[15], i_p0.x};
    w_x1 = {i_p1.x[15], i_p1.x};
    w_y0 = {i_p0.y[15], i_p0.y};
    w_y1 = {i_p1.y[15], i_p1.y};

    w_xl = (w_x0 < w_x1) ? w_x0 : w_x1;
    w_xh = (w_x0 < w_x1) ? w_x1 : w_x0;
    w_yl = (w_y0 < w_y1) ? w_y0 : w_y1;
    w_yh = (w_y0 < w_y1) ? w_y1 : w_y0;

    o_empty = (w_xh < ZERO) || (w_yh < ZERO) ||
              (w_xl > XMAX) || (w_yl > YMAX);

    w_xlc = (w_xl < ZERO) ? ZERO : ((w_xl > XMAX) ? XMAX : w_xl);
    w_xhc = (w_xh < ZERO) ? ZERO : ((w_xh > XMAX) ? XMAX : w_xh);
    w_ylc = (w_yl < ZERO) ? ZERO : ((w_yl > YMAX) ? YMAX : w_yl);
    w_yhc = (w_yh < ZERO) ? ZERO : ((w_yh > YMAX) ? YMAX : w_yh);

    o_xl = w_xlc[15:0];
    o_xh = w_xhc[15:0];
    o_yl = w_ylc[15:0];
    o_yh = w_yhc[15:0];
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Polls an SRAM command mailbox and rasterises clipped filled or
// outlined rectangles into the VGA pixel buffer, then acks.
module rect_fill_engine
  import rect_gpu_pkg::*;
#(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int PIX_W    = 8,
  parameter int VADDR_W  = 19,
  parameter int CMD_AW   = 8,
  parameter int CMD_BASE = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [CMD_AW-1:0]  sram_address,
  output logic               sram_clken,
  output logic               sram_chipselect,
  output logic               sram_write,
  output logic [31:0]        sram_writedata,
  output logic [3:0]         sram_byteenable,
  input  logic [31:0]        sram_readdata,
  output logic [VADDR_W-1:0] vga_address,
  output logic               vga_clken,
  output logic               vga_chipselect,
  output logic               vga_write,
  output logic [PIX_W-1:0]   vga_writedata,
  output logic               busy,
  output logic               done_pulse
);

  localparam logic [VADDR_W-1:0] HRES_V = VADDR_W'(H_RES);
  localparam logic [CMD_AW-1:0]  BASE_A = CMD_AW'(CMD_BASE);

  state_t             r_state;
  point_t             r_p0;
  point_t             r_p1;
  logic               r_outline;
  logic [PIX_W-1:0]   r_colour;
  logic [15:0]        r_x;
  logic [15:0]        r_y;
  logic [15:0]        r_xl;
  logic [15:0]        r_xh;
  logic [15:0]        r_yl;
  logic [15:0]        r_yh;
  logic [VADDR_W-1:0] r_addr;
  logic [VADDR_W-1:0] r_row_base;

  logic               w_empty;
  logic [15:0]        w_xl, w_xh, w_yl, w_yh;
  logic [VADDR_W-1:0] w_row_base;
  logic [VADDR_W-1:0] w_next_base;
  logic               w_row_end;
  logic               w_last;
  logic               w_skip;
  logic               w_live;
  logic               w_rd;
  logic               w_wr;
  logic               w_draw;
  logic [1:0]         w_off;

  rect_clip #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_clip (
    .i_p0    (r_p0),
    .i_p1    (r_p1),
    .o_empty (w_empty),
    .o_xl    (w_xl),
    .o_xh    (w_xh),
    .o_yl    (w_yl),
    .o_yh    (w_yh)
  );

  assign w_row_base  = VADDR_W'(w_yl) * HRES_V;
  assign w_next_base = r_row_base + HRES_V;
  assign w_row_end   = (r_x == r_xh);
  assign w_last      = w_row_end && (r_y == r_yh);
  // Outline interior rows only touch the two edge columns.
  assign w_skip      = r_outline && (r_y > r_yl) && (r_y < r_yh);

  always_comb begin
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_draw = 1'b0;
    w_off  = MB_CTRL;
    unique case (r_state)
      ST_POLL: w_rd = 1'b1;
      ST_RD1: begin
        w_rd  = 1'b1;
        w_off = MB_P0;
      end
      ST_RD2: begin
        w_rd  = 1'b1;
        w_off = MB_P1;
      end
      ST_RD3: begin
        w_rd  = 1'b1;
        w_off = MB_COLOUR;
      end
      ST_DRAW: w_draw = 1'b1;
      ST_ACK:  w_wr   = 1'b1;
      default: ;
    endcase
  end

  // Strobes are held low for the whole reset cycle.
  assign w_live = ~reset;

  assign sram_clken      = w_live & (w_rd | w_wr);
  assign sram_chipselect = w_live & (w_rd | w_wr);
  assign sram_write      = w_live & w_wr;
  assign sram_address    = (w_live & (w_rd | w_wr)) ?
                           BASE_A + CMD_AW'(w_off) : '0;
  assign sram_writedata  = (w_live & w_wr) ? DONE_WORD : '0;
  assign sram_byteenable = 4'hF;

  assign vga_clken       = w_live & w_draw;
  assign vga_chipselect  = w_live & w_draw;
  assign vga_write       = w_live & w_draw;
  assign vga_address     = (w_live & w_draw) ? r_addr : '0;
  assign vga_writedata   = (w_live & w_draw) ? r_colour : '0;

  assign busy       = w_live &&
                      (r_state != ST_POLL) && (r_state != ST_CHK);
  assign done_pulse = w_live & w_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_POLL;
      r_p0       <= '0;
      r_p1       <= '0;
      r_outline  <= 1'b0;
      r_colour   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_xl       <= '0;
      r_xh       <= '0;
      r_yl       <= '0;
      r_yh       <= '0;
      r_addr     <= '0;
      r_row_base <= '0;
    end else begin
      unique case (r_state)
        ST_POLL: r_state <= ST_CHK;
        ST_CHK: begin
          if (sram_readdata[BIT_GO]) begin
            r_outline <= sram_readdata[BIT_OUTLINE];
            r_state   <= ST_RD1;
          end else begin
            r_state   <= ST_POLL;
          end
        end
        ST_RD1: r_state <= ST_CAP1;
        ST_CAP1: begin
          r_p0    <= sram_readdata;
          r_state <= ST_RD2;
        end
        ST_RD2: r_state <= ST_CAP2;
        ST_CAP2: begin
          r_p1    <= sram_readdata;
          r_state <= ST_RD3;
        end
        ST_RD3: r_state <= ST_CAP3;
        ST_CAP3: begin
          r_colour <= sram_readdata[PIX_W-1:0];
          r_state  <= ST_CLIP;
        end
        ST_CLIP: begin
          if (w_empty) begin
            r_state <= ST_ACK;
          end else begin
            r_xl       <= w_xl;
            r_xh       <= w_xh;
            r_yl       <= w_yl;
            r_yh       <= w_yh;
            r_x        <= w_xl;
            r_y        <= w_yl;
            r_row_base <= w_row_base;
            r_addr     <= w_row_base + VADDR_W'(w_xl);
            r_state    <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (w_row_end) begin
            if (w_last) begin
              r_state <= ST_ACK;
            end else begin
              r_x        <= r_xl;
              r_y        <= r_y + 16'd1;
              r_row_base <= w_next_base;
              r_addr     <= w_next_base + VADDR_W'(r_xl);
            end
          end else if (w_skip) begin
            r_x    <= r_xh;
            r_addr <= r_row_base + VADDR_W'(r_xh);
          end else begin
            r_x    <= r_x + 16'd1;
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_ACK:  r_state <= ST_POLL;
        default: r_state <= ST_POLL;
      endcase
    end
  end

endmodule
